// File: rtl/mem_op_sequencer.sv
// Operand-pair read sequencer: streams len word pairs from two memory sectors
// through a 2-entry FIFO, with an independent writeback path to the memory.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads k = 0..len-1, throttled by FIFO credit
// DRAIN | all reads issued, waiting for the op_last pair to be accepted
// DONE  | one-cycle done pulse, then back to IDLE
module mem_op_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  cfg_sector_a,
    input  logic [3:0]  cfg_sector_b,
    input  logic [4:0]  cfg_len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [3:0]  read_sector_selector_1,
    output logic [3:0]  read_sector_selector_2,
    output logic [3:0]  read_add_1,
    output logic [3:0]  read_add_2,
    input  logic [15:0] read_data_1,
    input  logic [15:0] read_data_2,
    output logic        op_valid,
    input  logic        op_ready,
    output logic [15:0] op_a,
    output logic [15:0] op_b,
    output logic        op_last,
    input  logic        wb_valid,
    output logic        wb_ready,
    input  logic [3:0]  wb_sector,
    input  logic [3:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic        write_enable,
    output logic [3:0]  sector_write_select,
    output logic [3:0]  write_address,
    output logic [15:0] data_write
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [3:0] ROM_SECTOR = 4'hF;

    state_t      state_q, state_d;
    logic [3:0]  sec_a_q, sec_b_q;
    logic [4:0]  len_q;
    logic [4:0]  k_q;
    logic        inflight_q, inflight_last_q;
    logic [3:0]  rd_sec1_q, rd_sec2_q, rd_add_q;
    logic [15:0] fifo_a [2];
    logic [15:0] fifo_b [2];
    logic        fifo_last [2];
    logic        rd_ptr_q, wr_ptr_q;
    logic [1:0]  count_q;

    logic len_ok, start_accept, credit_ok, issue, issue_last;
    logic head_fifo, pop, fifo_pop, fifo_push;
    logic hazard, wb_accept, wb_rom, err_set;

    assign len_ok       = (cfg_len != 5'd0) && (cfg_len <= 5'd16);
    assign start_accept = (state_q == IDLE) && start;
    assign credit_ok    = (({1'b0, inflight_q} + count_q) < 2'd2);
    assign issue        = (state_q == RUN) && credit_ok;
    assign issue_last   = issue && (k_q == (len_q - 5'd1));
    assign head_fifo    = (count_q != 2'd0);
    assign pop          = op_valid && op_ready;
    assign fifo_pop     = pop && head_fifo;
    // Returning data bypasses straight to the outputs when the FIFO is empty
    // and is only stored if it is not consumed in its arrival cycle.
    assign fifo_push    = inflight_q && !(pop && !head_fifo);

    // Read-first: a read hitting the pending writeback location issues, the write waits a cycle.
    assign hazard    = issue && wb_valid && (k_q[3:0] == wb_addr) &&
                       ((sec_a_q == wb_sector) || (sec_b_q == wb_sector));
    assign wb_accept = wb_valid && wb_ready;
    assign wb_rom    = wb_accept && (wb_sector == ROM_SECTOR);
    assign err_set   = (start_accept && !len_ok) || wb_rom;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = len_ok ? RUN : DONE;
            RUN:     if (issue_last) state_d = DRAIN;
            DRAIN:   if (pop && op_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        op_valid = head_fifo || inflight_q;
        op_a     = '0;
        op_b     = '0;
        op_last  = 1'b0;
        if (head_fifo) begin
            op_a    = fifo_a[rd_ptr_q];
            op_b    = fifo_b[rd_ptr_q];
            op_last = fifo_last[rd_ptr_q];
        end else if (inflight_q) begin
            op_a    = read_data_1;
            op_b    = read_data_2;
            op_last = inflight_last_q;
        end
        read_sector_selector_1 = issue ? sec_a_q : rd_sec1_q;
        read_sector_selector_2 = issue ? sec_b_q : rd_sec2_q;
        read_add_1             = issue ? k_q[3:0] : rd_add_q;
        read_add_2             = issue ? k_q[3:0] : rd_add_q;
        wb_ready            = reset_n && !hazard;
        write_enable        = wb_accept && !wb_rom;
        sector_write_select = write_enable ? wb_sector : 4'd0;
        write_address       = write_enable ? wb_addr : 4'd0;
        data_write          = write_enable ? wb_data : 16'd0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sec_a_q         <= '0;
            sec_b_q         <= '0;
            len_q           <= '0;
            k_q             <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rd_sec1_q       <= '0;
            rd_sec2_q       <= '0;
            rd_add_q        <= '0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= '0;
            err             <= 1'b0;
        end else begin
            if (start_accept && len_ok) begin
                sec_a_q <= cfg_sector_a;
                sec_b_q <= cfg_sector_b;
                len_q   <= cfg_len;
                k_q     <= '0;
            end else if (issue) begin
                k_q <= k_q + 5'd1;
            end
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            if (issue) begin
                rd_sec1_q <= sec_a_q;
                rd_sec2_q <= sec_b_q;
                rd_add_q  <= k_q[3:0];
            end
            if (fifo_push) wr_ptr_q <= ~wr_ptr_q;
            if (fifo_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
            if (err_set)
                err <= 1'b1;
            else if (start_accept && len_ok)
                err <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (fifo_push) begin
            fifo_a[wr_ptr_q]    <= read_data_1;
            fifo_b[wr_ptr_q]    <= read_data_2;
            fifo_last[wr_ptr_q] <= inflight_last_q;
        end
    end

endmodule
